set_seq_ctrl: RTL and testbench

//  Parametrised job sequencer for the SET datapath: captures a job, clears the accumulator,

---
 rtl/set_seq_ctrl_pkg.sv | 23 ++
 rtl/set_seq_ctrl_coord_scanner.sv | 46 ++++
 rtl/set_seq_ctrl.sv | 114 +++++++++++
 tb/tb_set_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/set_seq_ctrl_pkg.sv
// Shared types and defaults for the SET job sequencer: state encoding,
// default grid/pipeline dimensions and a width helper.
package set_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SCAN  = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   localparam int unsigned DEF_X_DIM    = 8;
   localparam int unsigned DEF_Y_DIM    = 8;
   localparam int unsigned DEF_PIPE_LAT = 2;
   localparam int unsigned DRAIN_W      = 3;

   // Counter width for 0..n-1, never narrower than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/set_seq_ctrl_coord_scanner.sv
// Raster-order X/Y coordinate generator: x advances every step, y advances on x wrap.
// last_o flags the final grid point so the controller can stop stepping there.
module coord_scanner
   import set_seq_ctrl_pkg::*;
#(
   parameter int unsigned X_DIM = DEF_X_DIM,
   parameter int unsigned Y_DIM = DEF_Y_DIM,
   localparam int unsigned XW   = width_of(X_DIM),
   localparam int unsigned YW   = width_of(Y_DIM)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          clr_i,
   input  logic          step_i,
   output logic [XW-1:0] x_o,
   output logic [YW-1:0] y_o,
   output logic          last_o
);

   localparam logic [XW-1:0] X_LAST = XW'(X_DIM - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(Y_DIM - 1);

   logic [XW-1:0] x_q;
   logic [YW-1:0] y_q;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of its neighbours.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         x_q <= '0;
         y_q <= '0;
      end else if (step_i) begin
         if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= y_q + YW'(1);
         end else begin
            x_q <= x_q + XW'(1);
         end
      end
   end

   assign x_o    = x_q;
   assign y_o    = y_q;
   assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/set_seq_ctrl.sv
// SET job sequencer: IDLE -> LOAD -> SCAN -> DRAIN -> DONE, with abort,
// result back-pressure and a PIPE_LAT-deep accumulate-enable delay line.
module set_seq_ctrl
   import set_seq_ctrl_pkg::*;
#(
   parameter int unsigned X_DIM    = DEF_X_DIM,
   parameter int unsigned Y_DIM    = DEF_Y_DIM,
   parameter int unsigned PIPE_LAT = DEF_PIPE_LAT,
   localparam int unsigned XW      = width_of(X_DIM),
   localparam int unsigned YW      = width_of(Y_DIM)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          en_i,
   input  logic          abort_i,
   input  logic          ready_i,
   output logic          buffer_en_o,
   output logic          acc_clear_o,
   output logic          coord_vld_o,
   output logic [XW-1:0] coord_x_o,
   output logic [YW-1:0] coord_y_o,
   output logic          acc_en_o,
   output logic          busy_o,
   output logic          valid_o,
   output logic          clear_o
);

   localparam logic [DRAIN_W-1:0] DRAIN_LAST =
      DRAIN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

   state_e               state_q;
   logic [DRAIN_W-1:0]   drain_cnt_q;
   logic                 scan_last;
   logic                 in_idle;
   logic                 flush;

   assign in_idle = (state_q == S_IDLE);
   assign flush   = abort_i && !in_idle;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         drain_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (en_i) state_q <= S_LOAD;
            end
            S_LOAD: begin
               drain_cnt_q <= '0;
               state_q     <= abort_i ? S_IDLE : S_SCAN;
            end
            S_SCAN: begin
               if (abort_i)        state_q <= S_IDLE;
               else if (scan_last) state_q <= (PIPE_LAT > 0) ? S_DRAIN : S_DONE;
            end
            S_DRAIN: begin
               if (abort_i) begin
                  state_q     <= S_IDLE;
                  drain_cnt_q <= '0;
               end else if (drain_cnt_q == DRAIN_LAST) begin
                  state_q <= S_DONE;
               end else begin
                  drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
               end
            end
            S_DONE: begin
               if (abort_i || ready_i) state_q <= S_IDLE;
            end
            // NOTE: the explicit default steers any unused encoding back to IDLE
            // and keeps the case fully specified.
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Stepping stops at the last point so coordinates hold there after SCAN.
   coord_scanner #(
      .X_DIM (X_DIM),
      .Y_DIM (Y_DIM)
   ) u_scanner (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  ((state_q == S_LOAD) || flush),
      .step_i ((state_q == S_SCAN) && !abort_i && !scan_last),
      .x_o    (coord_x_o),
      .y_o    (coord_y_o),
      .last_o (scan_last)
   );

   assign buffer_en_o = in_idle && en_i;
   assign acc_clear_o = (state_q == S_LOAD);
   assign coord_vld_o = (state_q == S_SCAN);
   assign busy_o      = (state_q == S_LOAD) || (state_q == S_SCAN) ||
                        (state_q == S_DRAIN) || (state_q == S_DONE);
   assign valid_o     = (state_q == S_DONE);
   assign clear_o     = valid_o && ready_i;

   generate
      if (PIPE_LAT == 0) begin : g_no_pipe
         assign acc_en_o = coord_vld_o;
      end else begin : g_pipe
         logic [PIPE_LAT-1:0] pipe_q;

         always_ff @(posedge clk_i) begin
            if (rst_i || flush) pipe_q <= '0;
            else                pipe_q <= (pipe_q << 1) | PIPE_LAT'(coord_vld_o);
         end

         assign acc_en_o = pipe_q[PIPE_LAT-1];
      end
   endgenerate

endmodule

// File: tb/tb_set_seq_ctrl.sv
// Directed bench for set_seq_ctrl: three configurations (4x4/L2, 3x2/L1, 3x2/L0)
// stepped cycle by cycle against hand-computed timing tables.
module tb_set_seq_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic       a_en, a_abort, a_ready;
   logic       a_buf, a_clr, a_vld, a_acc, a_busy, a_valid, a_clear;
   logic [1:0] a_x, a_y;

   logic       b_en, b_abort, b_ready;
   logic       b_buf, b_clr, b_vld, b_acc, b_busy, b_valid, b_clear;
   logic [1:0] b_x;
   logic       b_y;

   logic       c_en, c_abort, c_ready;
   logic       c_buf, c_clr, c_vld, c_acc, c_busy, c_valid, c_clear;
   logic [1:0] c_x;
   logic       c_y;

   set_seq_ctrl #(.X_DIM(4), .Y_DIM(4), .PIPE_LAT(2)) u_a (
      .clk_i(clk), .rst_i(rst), .en_i(a_en), .abort_i(a_abort), .ready_i(a_ready),
      .buffer_en_o(a_buf), .acc_clear_o(a_clr), .coord_vld_o(a_vld),
      .coord_x_o(a_x), .coord_y_o(a_y), .acc_en_o(a_acc), .busy_o(a_busy),
      .valid_o(a_valid), .clear_o(a_clear));

   set_seq_ctrl #(.X_DIM(3), .Y_DIM(2), .PIPE_LAT(1)) u_b (
      .clk_i(clk), .rst_i(rst), .en_i(b_en), .abort_i(b_abort), .ready_i(b_ready),
      .buffer_en_o(b_buf), .acc_clear_o(b_clr), .coord_vld_o(b_vld),
      .coord_x_o(b_x), .coord_y_o(b_y), .acc_en_o(b_acc), .busy_o(b_busy),
      .valid_o(b_valid), .clear_o(b_clear));

   set_seq_ctrl #(.X_DIM(3), .Y_DIM(2), .PIPE_LAT(0)) u_c (
      .clk_i(clk), .rst_i(rst), .en_i(c_en), .abort_i(c_abort), .ready_i(c_ready),
      .buffer_en_o(c_buf), .acc_clear_o(c_clr), .coord_vld_o(c_vld),
      .coord_x_o(c_x), .coord_y_o(c_y), .acc_en_o(c_acc), .busy_o(c_busy),
      .valid_o(c_valid), .clear_o(c_clear));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // {buffer_en, acc_clear, coord_vld, acc_en, busy, valid, clear}
   function automatic logic [31:0] a_vec();
      return 32'({a_buf, a_clr, a_vld, a_acc, a_busy, a_valid, a_clear});
   endfunction
   function automatic logic [31:0] b_vec();
      return 32'({b_buf, b_clr, b_vld, b_acc, b_busy, b_valid, b_clear});
   endfunction
   function automatic logic [31:0] c_vec();
      return 32'({c_buf, c_clr, c_vld, c_acc, c_busy, c_valid, c_clear});
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not reach its end");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt_v, cnt_c, cnt_a, cnt_i;
      logic [31:0] exp_v;

      rst = 1'b1;
      a_en = 1'b1; a_abort = 1'b0; a_ready = 1'b0;
      b_en = 1'b0; b_abort = 1'b1; b_ready = 1'b1;
      c_en = 1'b0; c_abort = 1'b0; c_ready = 1'b0;
      tick();
      tick();
      check("reset_a_outputs", a_vec(), 32'b1000000);
      check("reset_b_outputs", b_vec(), 32'd0);
      check("reset_c_outputs", c_vec(), 32'd0);
      check("reset_coords", 32'({a_x, a_y, b_x, b_y, c_x, c_y}), 32'd0);
      a_en = 1'b0; b_abort = 1'b0; b_ready = 1'b0;
      rst = 1'b0;
      tick();

      // T1: 4x4, latency 2, single job with immediate ready
      for (int c = 0; c <= 21; c++) begin
         a_en = (c == 0); a_ready = (c == 20);
         #1;
         exp_v = 32'({(c == 0), (c == 1), (c >= 2 && c <= 17), (c >= 4 && c <= 19),
                      (c >= 1 && c <= 20), (c == 20), (c == 20)});
         check("t1_controls", a_vec(), exp_v);
         if (c >= 2 && c <= 17)
            check("t1_coords", 32'({a_x, a_y}), 32'({2'((c - 2) % 4), 2'((c - 2) / 4)}));
         tick();
      end
      a_ready = 1'b0;

      // T3: result back-pressure, ready_i low for cycles 20..24
      cnt_v = 0; cnt_c = 0;
      for (int c = 0; c <= 27; c++) begin
         a_en = (c == 0); a_ready = (c == 25);
         #1;
         cnt_v += int'(a_valid);
         cnt_c += int'(a_clear);
         if (c == 24) check("t3_valid_held", 32'({a_valid, a_clear}), 32'b10);
         if (c == 26) check("t3_idle_after", 32'(a_busy), 32'd0);
         tick();
      end
      a_ready = 1'b0;
      check("t3_valid_cycles", 32'(cnt_v), 32'd6);
      check("t3_clear_pulses", 32'(cnt_c), 32'd1);

      // T6: en_i held high, ready_i high -> jobs every 21 cycles
      a_en = 1'b1; a_ready = 1'b1;
      cnt_c = 0; cnt_a = 0; cnt_i = 0;
      for (int c = 0; c <= 44; c++) begin
         #1;
         cnt_c += int'(a_clr);
         cnt_a += int'(a_acc);
         cnt_i += int'(!a_busy);
         if (c == 20 || c == 41) check("t6_valid", 32'({a_valid, a_clear}), 32'b11);
         if (c == 21 || c == 42) check("t6_idle_gap", 32'({a_busy, a_buf}), 32'b01);
         tick();
      end
      check("t6_loads", 32'(cnt_c), 32'd3);
      check("t6_acc_pulses", 32'(cnt_a), 32'd32);
      check("t6_idle_cycles", 32'(cnt_i), 32'd3);
      a_en = 1'b0; a_abort = 1'b1;
      #1;
      check("t6_in_scan", 32'(a_vld), 32'd1);
      tick();
      a_abort = 1'b0;
      #1;
      check("t6_abort_outputs", a_vec(), 32'd0);
      check("t6_abort_coords", 32'({a_x, a_y}), 32'd0);
      a_ready = 1'b0;

      // T2: 3x2, latency 1, coordinate raster and hold
      cnt_a = 0;
      for (int c = 0; c <= 10; c++) begin
         b_en = (c == 0); b_ready = (c == 9);
         #1;
         cnt_a += int'(b_acc);
         if (c >= 2 && c <= 7)
            check("t2_coords", 32'({b_x, b_y}), 32'({2'((c - 2) % 3), 1'((c - 2) / 3)}));
         if (c >= 8)
            check("t2_coord_hold", 32'({b_x, b_y}), 32'b101);
         if (c == 9) check("t2_done", 32'({b_valid, b_clear}), 32'b11);
         tick();
      end
      b_ready = 1'b0;
      check("t2_acc_pulses", 32'(cnt_a), 32'd6);

      // T4: abort in SCAN at (2,1), then a clean job
      for (int c = 0; c <= 7; c++) begin
         b_en = (c == 0); b_abort = (c == 7);
         #1;
         if (c == 7) check("t4_at_2_1", 32'({b_vld, b_x, b_y}), 32'b1101);
         tick();
      end
      b_abort = 1'b0;
      #1;
      check("t4_after_abort", 32'({b_busy, b_acc, b_x, b_y}), 32'd0);
      cnt_v = 0;
      for (int c = 0; c < 6; c++) begin
         tick();
         cnt_v += int'(b_valid | b_busy);
      end
      check("t4_no_valid", 32'(cnt_v), 32'd0);
      cnt_a = 0;
      for (int c = 0; c <= 10; c++) begin
         b_en = (c == 0); b_ready = (c == 9);
         #1;
         cnt_a += int'(b_acc);
         if (c == 9)  check("t4_rerun_done", 32'({b_valid, b_clear}), 32'b11);
         if (c == 10) check("t4_rerun_idle", 32'(b_busy), 32'd0);
         tick();
      end
      b_ready = 1'b0;
      check("t4_rerun_acc", 32'(cnt_a), 32'd6);

      // T5: latency 0, acc_en tracks coord_vld, done in cycle 8
      for (int c = 0; c <= 9; c++) begin
         c_en = (c == 0); c_ready = (c == 8);
         #1;
         check("t5_vld_acc", 32'({c_vld, c_acc}), 32'({2{(c >= 2 && c <= 7)}}));
         check("t5_valid", 32'({c_valid, c_clear}), 32'({2{(c == 8)}}));
         tick();
      end
      c_ready = 1'b0;
      for (int c = 0; c <= 4; c++) begin
         c_en = (c == 0);
         #1;
         tick();
      end
      check("t5_mid_scan", 32'({c_vld, c_x, c_y}), 32'b1001);
      rst = 1'b1; c_abort = 1'b1; c_ready = 1'b1;
      tick();
      check("t5_reset_outputs", c_vec(), 32'd0);
      check("t5_reset_coords", 32'({c_x, c_y}), 32'd0);
      rst = 1'b0; c_abort = 1'b0; c_ready = 1'b0;
      tick();
      check("t5_stays_idle", c_vec(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
